// File: rtl/i2c_host_ctrl.sv
// Host command sequencer in front of the I2C master: latches one command, feeds write bytes
// from a TX FIFO, and captures read bytes into an RX FIFO. done pulses two cycles after m_done.

module i2c_host_fifo #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       push_i,
    input  logic [7:0] din_i,
    input  logic       pop_i,
    output logic [7:0] dout_o,
    output logic       full_o,
    output logic       empty_o
);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic [7:0]       last_q;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    // A pop on empty never sees the byte being pushed in the same cycle.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_i);
    assign dout_o  = empty_o ? last_q : mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din_i;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                last_q   <= mem_q[rd_ptr_q];
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

module i2c_host_ctrl #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_addr,
    input  logic       cmd_rw,
    input  logic [3:0] cmd_nbyte,
    input  logic       tx_wr,
    input  logic [7:0] tx_data,
    output logic       tx_full,
    input  logic       rx_rd,
    output logic [7:0] rx_data,
    output logic       rx_empty,
    output logic       busy,
    output logic       done,
    output logic       err_len,
    output logic       err_underrun,
    output logic       err_overrun,
    output logic       m_en,
    output logic [6:0] m_address,
    output logic       m_rw,
    output logic [3:0] m_N_byte,
    output logic [7:0] m_data_in,
    input  logic       m_byte_req,
    input  logic       m_rx_valid,
    input  logic [7:0] m_data_out,
    input  logic       m_done
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, FINISH} state_t;

    state_t     state_q;
    logic [3:0] remaining_q;
    logic       m_en_q, busy_q, done_q;
    logic       err_len_q, err_underrun_q, err_overrun_q;
    logic [6:0] m_address_q;
    logic       m_rw_q;
    logic [3:0] m_N_byte_q;
    logic [7:0] m_data_in_q;

    logic       tx_pop, tx_empty;
    logic [7:0] tx_head;
    logic       rx_push, rx_full, overrun;
    logic       wr_evt;

    assign wr_evt  = (state_q == RUN) && !m_rw_q && m_byte_req;
    // Next byte is fetched only while more remain after this request.
    assign tx_pop  = ((state_q == LOAD) && !m_rw_q) || (wr_evt && (remaining_q > 4'd1));
    assign rx_push = (state_q == RUN) && m_rw_q && m_rx_valid;
    assign overrun = rx_push && rx_full && !rx_rd;

    i2c_host_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_tx_fifo (
        .clk     (clk),
        .resetN  (resetN),
        .push_i  (tx_wr),
        .din_i   (tx_data),
        .pop_i   (tx_pop),
        .dout_o  (tx_head),
        .full_o  (tx_full),
        .empty_o (tx_empty)
    );

    i2c_host_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rx_fifo (
        .clk     (clk),
        .resetN  (resetN),
        .push_i  (rx_push),
        .din_i   (m_data_out),
        .pop_i   (rx_rd),
        .dout_o  (rx_data),
        .full_o  (rx_full),
        .empty_o (rx_empty)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q        <= IDLE;
            remaining_q    <= '0;
            m_en_q         <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_len_q      <= 1'b0;
            err_underrun_q <= 1'b0;
            err_overrun_q  <= 1'b0;
            m_address_q    <= '0;
            m_rw_q         <= 1'b0;
            m_N_byte_q     <= '0;
            m_data_in_q    <= '0;
        end else begin
            done_q <= (state_q == FINISH);
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        m_address_q    <= cmd_addr;
                        m_rw_q         <= cmd_rw;
                        m_N_byte_q     <= cmd_nbyte;
                        remaining_q    <= cmd_nbyte;
                        err_underrun_q <= 1'b0;
                        err_overrun_q  <= 1'b0;
                        if (cmd_nbyte == 4'd0) begin
                            err_len_q <= 1'b1;
                            state_q   <= FINISH;
                        end else begin
                            err_len_q <= 1'b0;
                            busy_q    <= 1'b1;
                            state_q   <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (m_rw_q) begin
                        m_data_in_q <= 8'h00;
                    end else begin
                        m_data_in_q <= tx_empty ? 8'hFF : tx_head;
                        if (tx_empty) err_underrun_q <= 1'b1;
                    end
                    m_en_q  <= 1'b1;
                    state_q <= RUN;
                end
                RUN: begin
                    if (wr_evt && (remaining_q != 4'd0)) begin
                        remaining_q <= remaining_q - 4'd1;
                    end
                    if (tx_pop) begin
                        m_data_in_q <= tx_empty ? 8'hFF : tx_head;
                        if (tx_empty) err_underrun_q <= 1'b1;
                    end
                    if (overrun) err_overrun_q <= 1'b1;
                    if (m_done) begin
                        m_en_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= FINISH;
                    end
                end
                FINISH: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready    = (state_q == IDLE);
    assign busy         = busy_q;
    assign done         = done_q;
    assign err_len      = err_len_q;
    assign err_underrun = err_underrun_q;
    assign err_overrun  = err_overrun_q;
    assign m_en         = m_en_q;
    assign m_address    = m_address_q;
    assign m_rw         = m_rw_q;
    assign m_N_byte     = m_N_byte_q;
    assign m_data_in    = m_data_in_q;
endmodule

// File: tb/tb_i2c_host_ctrl.sv
// Directed bench for i2c_host_ctrl: write, read, underrun, overrun, zero length, full-FIFO push/pop, mid-run reset.
module tb_i2c_host_ctrl;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [6:0] cmd_addr = '0;
    logic       cmd_rw = 1'b0;
    logic [3:0] cmd_nbyte = '0;
    logic       tx_wr = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_full;
    logic       rx_rd = 1'b0;
    logic [7:0] rx_data;
    logic       rx_empty;
    logic       busy, done, err_len, err_underrun, err_overrun;
    logic       m_en;
    logic [6:0] m_address;
    logic       m_rw;
    logic [3:0] m_N_byte;
    logic [7:0] m_data_in;
    logic       m_byte_req = 1'b0;
    logic       m_rx_valid = 1'b0;
    logic [7:0] m_data_out = '0;
    logic       m_done = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    i2c_host_ctrl #(.DEPTH(DEPTH), .PTR_W(3)) dut (
        .clk(clk), .resetN(resetN),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_rw(cmd_rw), .cmd_nbyte(cmd_nbyte),
        .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full),
        .rx_rd(rx_rd), .rx_data(rx_data), .rx_empty(rx_empty),
        .busy(busy), .done(done), .err_len(err_len),
        .err_underrun(err_underrun), .err_overrun(err_overrun),
        .m_en(m_en), .m_address(m_address), .m_rw(m_rw), .m_N_byte(m_N_byte),
        .m_data_in(m_data_in), .m_byte_req(m_byte_req), .m_rx_valid(m_rx_valid),
        .m_data_out(m_data_out), .m_done(m_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_tx(input logic [7:0] d);
        tx_wr = 1'b1; tx_data = d;
        tick();
        tx_wr = 1'b0;
    endtask

    task automatic issue(input logic [6:0] a, input logic rw, input logic [3:0] n);
        cmd_valid = 1'b1; cmd_addr = a; cmd_rw = rw; cmd_nbyte = n;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic byte_req();
        m_byte_req = 1'b1;
        tick();
        m_byte_req = 1'b0;
    endtask

    task automatic rx_beat(input logic [7:0] d);
        m_rx_valid = 1'b1; m_data_out = d;
        tick();
        m_rx_valid = 1'b0;
    endtask

    task automatic pop_rx();
        rx_rd = 1'b1;
        tick();
        rx_rd = 1'b0;
    endtask

    task automatic finish_txn(input string tag);
        m_done = 1'b1;
        tick();
        m_done = 1'b0;
        chk({tag, "_men_off"}, m_en, 0);
        chk({tag, "_done_early"}, done, 0);
        tick();
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ready"}, cmd_ready, 1);
        tick();
        chk({tag, "_done_pulse"}, done, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        #1;
        chk("rst_ready", cmd_ready, 1);
        chk("rst_txfull", tx_full, 0);
        chk("rst_rxempty", rx_empty, 1);
        chk("rst_rxdata", rx_data, 0);
        chk("rst_men", m_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_errs", {err_len, err_underrun, err_overrun}, 0);
        chk("rst_maddr", {m_address, m_rw, m_N_byte}, 0);
        chk("rst_mdata", m_data_in, 0);
        tick();
        resetN = 1'b1;
        tick();

        // Write of 3 bytes
        push_tx(8'hA5); push_tx(8'h3C); push_tx(8'h0F);
        issue(7'h50, 1'b0, 4'd3);
        chk("wr_ready", cmd_ready, 0);
        chk("wr_busy", busy, 1);
        chk("wr_men_load", m_en, 0);
        chk("wr_latch", {m_address, m_rw, m_N_byte}, {7'h50, 1'b0, 4'd3});
        tick();
        chk("wr_men", m_en, 1);
        chk("wr_b0", m_data_in, 8'hA5);
        byte_req();
        chk("wr_b1", m_data_in, 8'h3C);
        byte_req();
        chk("wr_b2", m_data_in, 8'h0F);
        byte_req();
        chk("wr_nopop", m_data_in, 8'h0F);
        finish_txn("wr");
        chk("wr_errs", {err_len, err_underrun, err_overrun}, 0);

        // Read of 4 bytes
        issue(7'h21, 1'b1, 4'd4);
        tick();
        chk("rd_men", m_en, 1);
        chk("rd_mdata", m_data_in, 0);
        rx_beat(8'h11);
        chk("rd_head", rx_data, 8'h11);
        chk("rd_nempty", rx_empty, 0);
        rx_beat(8'h22); rx_beat(8'h33); rx_beat(8'h44);
        finish_txn("rd");
        chk("rd_ovr", err_overrun, 0);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] e;
            e = 8'(8'h11 * (i + 1));
            chk($sformatf("rd_pop%0d", i), rx_data, e);
            pop_rx();
        end
        chk("rd_empty", rx_empty, 1);
        chk("rd_hold", rx_data, 8'h44);
        pop_rx();
        chk("rd_hold2", rx_data, 8'h44);

        // Underrun: 2-byte write with a single queued byte
        push_tx(8'h77);
        issue(7'h10, 1'b0, 4'd2);
        tick();
        chk("un_b0", m_data_in, 8'h77);
        chk("un_flag0", err_underrun, 0);
        byte_req();
        chk("un_ff", m_data_in, 8'hFF);
        chk("un_flag", err_underrun, 1);
        byte_req();
        finish_txn("un");
        chk("un_sticky", err_underrun, 1);

        // Overrun: DEPTH bytes fill RX, the next is dropped
        issue(7'h33, 1'b1, 4'd9);
        chk("ov_un_clr", err_underrun, 0);
        tick();
        for (int i = 0; i < DEPTH; i++) rx_beat(8'(8'h80 + i));
        chk("ov_flag0", err_overrun, 0);
        rx_beat(8'h99);
        chk("ov_flag", err_overrun, 1);
        finish_txn("ov");
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("ov_pop%0d", i), rx_data, 8'(8'h80 + i));
            pop_rx();
        end
        chk("ov_empty", rx_empty, 1);

        // Zero-length command
        issue(7'h44, 1'b0, 4'd0);
        chk("len_flag", err_len, 1);
        chk("len_men", m_en, 0);
        chk("len_done0", done, 0);
        tick();
        chk("len_done", done, 1);
        chk("len_men2", m_en, 0);
        tick();
        chk("len_done_pulse", done, 0);

        // Full TX: simultaneous push and pop keeps count at DEPTH
        for (int i = 0; i < DEPTH; i++) push_tx(8'(8'hB0 + i));
        chk("full_tx", tx_full, 1);
        push_tx(8'hE9);
        issue(7'h55, 1'b0, 4'd9);
        chk("full_len_clr", err_len, 0);
        tx_wr = 1'b1; tx_data = 8'hB8;
        tick();
        tx_wr = 1'b0;
        chk("full_b0", m_data_in, 8'hB0);
        chk("full_still", tx_full, 1);
        for (int i = 1; i <= DEPTH; i++) begin
            byte_req();
            chk($sformatf("full_b%0d", i), m_data_in, 8'(8'hB0 + i));
        end
        chk("full_drained", tx_full, 0);
        byte_req();
        chk("full_nopop", m_data_in, 8'hB8);
        chk("full_un", err_underrun, 0);
        finish_txn("full");

        // Reset mid-RUN
        for (int i = 1; i <= 5; i++) push_tx(8'(8'hC0 + i));
        issue(7'h66, 1'b0, 4'd5);
        tick();
        byte_req(); byte_req();
        chk("mr_b2", m_data_in, 8'hC3);
        chk("mr_men", m_en, 1);
        resetN = 1'b0;
        #1;
        chk("mr_men_async", m_en, 0);
        chk("mr_ready", cmd_ready, 1);
        tick();
        chk("mr_nodone", done, 0);
        resetN = 1'b1;
        tick();
        chk("mr_nodone2", done, 0);
        chk("mr_rxempty", rx_empty, 1);
        chk("mr_busy", busy, 0);

        // TX must be empty after reset: a 1-byte write underruns
        issue(7'h70, 1'b0, 4'd1);
        tick();
        chk("post_ff", m_data_in, 8'hFF);
        chk("post_un", err_underrun, 1);
        finish_txn("post");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
